// File: rtl/rx_ber_checker.sv
// Receiver-side BER checker: downsamples and slices the shaped sample stream, searches for the
// reference delay that lines up with the transmitted PRBS, then counts bits and errors once locked.
module rx_ber_checker #(
  parameter int unsigned NB_SAMPLE  = 12,
  parameter int unsigned OVER_SAMP  = 8,
  parameter int unsigned NB_COUNT   = 3,
  parameter int unsigned MAX_DELAY  = 32,
  parameter int unsigned NB_DELAY   = 5,
  parameter int unsigned SEARCH_LEN = 64,
  parameter int unsigned NB_SEARCH  = 7,
  parameter int unsigned NB_BER     = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [NB_SAMPLE-1:0] i_sample,
  input  logic [NB_COUNT-1:0]  i_phase,
  input  logic                 i_valid,
  input  logic                 i_prbs,
  output logic                 o_locked,
  output logic [NB_DELAY-1:0]  o_delay,
  output logic [NB_BER-1:0]    o_bit_count,
  output logic [NB_BER-1:0]    o_err_count
);

  typedef enum logic {StSearch = 1'b0, StLocked = 1'b1} state_e;

  state_e               r_state, w_state_d;
  logic [NB_COUNT-1:0]  r_phase_cnt;
  logic                 r_rx_bit;
  logic                 r_dec_valid;
  logic                 r_cmp_valid;
  logic                 r_mismatch;
  logic [MAX_DELAY-1:0] r_ref;
  logic [NB_SEARCH-1:0] r_srch_cnt, w_srch_cnt_d, w_srch_cnt_inc;
  logic                 r_srch_err, w_srch_err_d;
  logic [NB_DELAY-1:0]  r_delay, w_delay_d;
  logic [NB_BER-1:0]    r_bit_count, w_bit_count_d;
  logic [NB_BER-1:0]    r_err_count, w_err_count_d;
  logic                 w_capture;
  logic                 w_unused_sample;

  // Only the sign of the sample carries the decision.
  assign w_unused_sample = ^i_sample[NB_SAMPLE-2:0];

  assign w_capture      = (r_phase_cnt == i_phase);
  assign w_srch_cnt_inc = r_srch_cnt + 1'b1;

  // Datapath: capture -> compare, one stage each; compare uses the pre-shift reference buffer.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_phase_cnt <= '0;
      r_rx_bit    <= 1'b0;
      r_dec_valid <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_mismatch  <= 1'b0;
      r_ref       <= '0;
    end else if (i_enable) begin
      r_phase_cnt <= (r_phase_cnt == NB_COUNT'(OVER_SAMP - 1)) ? '0 : r_phase_cnt + 1'b1;
      r_dec_valid <= w_capture;
      if (w_capture) begin
        r_rx_bit <= i_sample[NB_SAMPLE-1];
      end
      r_cmp_valid <= r_dec_valid;
      r_mismatch  <= r_rx_bit ^ r_ref[r_delay];
      if (i_valid) begin
        r_ref <= {r_ref[MAX_DELAY-2:0], i_prbs};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_state     <= StSearch;
      r_srch_cnt  <= '0;
      r_srch_err  <= 1'b0;
      r_delay     <= '0;
      r_bit_count <= '0;
      r_err_count <= '0;
    end else if (i_enable) begin
      r_state     <= w_state_d;
      r_srch_cnt  <= w_srch_cnt_d;
      r_srch_err  <= w_srch_err_d;
      r_delay     <= w_delay_d;
      r_bit_count <= w_bit_count_d;
      r_err_count <= w_err_count_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_srch_cnt_d  = r_srch_cnt;
    w_srch_err_d  = r_srch_err;
    w_delay_d     = r_delay;
    w_bit_count_d = r_bit_count;
    w_err_count_d = r_err_count;
    unique case (r_state)
      StSearch: begin
        if (r_cmp_valid) begin
          if (w_srch_cnt_inc == NB_SEARCH'(SEARCH_LEN)) begin
            // Window complete: the closing comparison still decides the outcome.
            w_srch_cnt_d = '0;
            w_srch_err_d = 1'b0;
            if (r_srch_err || r_mismatch) begin
              w_delay_d = (r_delay == NB_DELAY'(MAX_DELAY - 1)) ? '0 : r_delay + 1'b1;
            end else begin
              w_state_d = StLocked;
            end
          end else begin
            w_srch_cnt_d = w_srch_cnt_inc;
            w_srch_err_d = r_srch_err | r_mismatch;
          end
        end
      end
      StLocked: begin
        if (r_cmp_valid) begin
          if (!(&r_bit_count)) begin
            w_bit_count_d = r_bit_count + 1'b1;
          end
          if (r_mismatch && !(&r_err_count)) begin
            w_err_count_d = r_err_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StSearch;
      end
    endcase
  end

  assign o_locked    = (r_state == StLocked);
  assign o_delay     = r_delay;
  assign o_bit_count = r_bit_count;
  assign o_err_count = r_err_count;

endmodule
